flit_stream_arbiter: RTL and testbench
======================================

# flit_stream_arbiter

Message-aware round-robin arbiter merging NUM_IN accelerator flit streams onto one mailbox-mesh injection port. Sits between a group of ExternalTinselAccelerator-style blocks and the tile's NoC router. Grants whole messages: once the first flit of a multi-flit message is accepted, the port stays granted until its final flit (notFinalFlit == 0). Single registered output slot gives one cycle of latency and full throughput.

## Interface

- NUM_IN, default 4, number of input streams (2..16)
- LOG_IN, default $clog2(NUM_IN), width of grant index

- clk  input  1  clock; all state updates on negedge clk (BSV synchronisation)
- rst_n  input  1  synchronous, active-high reset (asserted when 1), sampled on the clock edge
- in_data  input  NUM_IN x Flit  per-port input flit
- in_valid  input  NUM_IN  per-port valid
- in_ready  output  NUM_IN  per-port ready (at most one bit set)
- out_data  output  Flit  registered output flit
- out_valid  output  1  output slot full
- out_ready  input  1  downstream accepts
- locked  output  1  mid-message lock held
- grant_idx  output  LOG_IN  locked port, or last winner when not locked

## Operation

- State: outFull, outData, lock (0/1), lockIdx, rrPtr (LOG_IN bits).
- Slot free this cycle: slotFree = !outFull || out_ready.
- Winner selection (combinational):
  - lock == 1: winner = lockIdx, eligible only if in_valid[lockIdx]; other ports never win.
  - lock == 0: first i with in_valid[i] set, scanning rrPtr, rrPtr+1, ..., wrapping mod NUM_IN.
- in_ready[winner] = slotFree && in_valid[winner] && !rst_n; all other bits 0. in_ready depends on in_valid; downstream of in_ready must not feed back into in_valid.
- Transfer on port w when in_valid[w] && in_ready[w]: outData <= in_data[w] unmodified; outFull <= 1.
- Drain: outFull && out_ready with no transfer -> outFull <= 0. Drain and transfer in the same cycle -> outFull stays 1, outData replaced.
- Lock transitions on transfer from w:
  - notFinalFlit == 1: lock <= 1, lockIdx <= w (stays 1 if already locked).
  - notFinalFlit == 0: lock <= 0, rrPtr <= (w+1) mod NUM_IN (wrap at NUM_IN-1 -> 0, not power-of-two arithmetic).
- isIdleToken flits pass through unmodified and are arbitrated like ordinary flits; they carry notFinalFlit == 0, so they never create a lock.
- While locked and in_valid[lockIdx] == 0, no port is served (output may bubble); no timeout.
- grant_idx = lockIdx when locked, else the last winner (0 after reset).

## Timing

- Reset (rst_n == 1 on edge): outFull=0, lock=0, lockIdx=0, rrPtr=0, grant_idx=0. Outputs during and after reset: out_valid=0, locked=0, in_ready=0 while rst_n==1.
- Reset mid-message drops the lock and discards outData; upstream must restart the message.
- Latency: flit accepted at edge N appears on out_data/out_valid immediately after edge N; it is held stable until the edge where out_ready==1.
- Throughput: 1 flit/cycle while out_ready==1 and a winner is valid.
- Backpressure: outFull && !out_ready -> all in_ready=0; out_data holds.
- Fairness: with all ports continuously valid and single-flit messages, grants rotate 0,1,...,NUM_IN-1,0.

## Test plan

- Reset: hold rst_n=1 for 3 cycles with all in_valid=1 -> in_ready=0, out_valid=0, locked=0 throughout; first grant after release goes to port 0.
- Round robin: NUM_IN=4, all ports valid with single-flit messages and out_ready=1 -> output order 0,1,2,3,0,1; one flit per cycle with no bubbles.
- Message lock: port 2 sends 3 flits (notFinalFlit 1,1,0) while ports 0,3 stay valid -> the 3 flits are output contiguously, locked=1 for 2 cycles, and the next grant goes to port 3.
- Lock stall: port 1 locked, in_valid[1] low for 4 cycles while port 0 is valid -> in_ready[0]=0 and out_valid drops after drain; port 1 resumes and completes its message.
- Backpressure: out_ready=0 for 5 cycles with a full slot -> out_data stable, all in_ready=0; on out_ready=1, drain and refill happen in the same cycle with out_valid staying 1.
- Reset mid-message: rst_n=1 after the 1st of 3 flits from port 2 -> locked=0, out_valid=0, rrPtr=0; after release port 0 is granted first.

Source files
------------

// File: rtl/flit_stream_arbiter.sv
// Message-aware round-robin arbiter merging NUM_IN flit streams into one registered output slot.
// Flit layout: bit FLIT_W-1 is notFinalFlit, bit FLIT_W-2 is isIdleToken; flits pass through untouched.
module flit_stream_arbiter #(
  parameter int NUM_IN = 4,
  parameter int LOG_IN = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
  parameter int FLIT_W = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_IN-1:0][FLIT_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]              in_valid,
  output logic [NUM_IN-1:0]              in_ready,
  output logic [FLIT_W-1:0]              out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           locked,
  output logic [LOG_IN-1:0]              grant_idx
);

  // Handshake: a flit moves on port i in a cycle where in_valid[i] && in_ready[i]
  // at the committing (falling) clock edge; the output slot drains where out_valid && out_ready.

  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_e;

  lock_state_e         state_q, state_d;
  logic [LOG_IN-1:0]   lock_idx_q, lock_idx_d;
  logic [LOG_IN-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LOG_IN-1:0]   last_win_q, last_win_d;
  logic                out_full_q, out_full_d;
  logic [FLIT_W-1:0]   out_data_q, out_data_d;

  logic [LOG_IN-1:0]   win_idx;
  logic [LOG_IN-1:0]   cand;
  logic                win_ok;
  logic                slot_free;
  logic                xfer;

  function automatic logic [LOG_IN-1:0] wrap_add(input logic [LOG_IN-1:0] base,
                                                 input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(NUM_IN)) sum = sum - 32'(NUM_IN);
    return sum[LOG_IN-1:0];
  endfunction

  // While a message is in flight only its own port may win, even if it goes idle.
  always_comb begin
    win_idx = rr_ptr_q;
    win_ok  = 1'b0;
    cand    = rr_ptr_q;
    if (state_q == ST_LOCKED) begin
      win_idx = lock_idx_q;
      win_ok  = in_valid[lock_idx_q];
    end else begin
      for (int unsigned k = 0; k < NUM_IN; k++) begin
        cand = wrap_add(rr_ptr_q, k);
        if (!win_ok && in_valid[cand]) begin
          win_idx = cand;
          win_ok  = 1'b1;
        end
      end
    end
  end

  assign slot_free = !out_full_q || out_ready;
  assign xfer      = win_ok && slot_free && !rst_n;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[win_idx] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    last_win_d = last_win_q;
    out_full_d = out_full_q;
    out_data_d = out_data_q;
    if (xfer) begin
      out_data_d = in_data[win_idx];
      out_full_d = 1'b1;
      last_win_d = win_idx;
      if (in_data[win_idx][FLIT_W-1]) begin
        state_d    = ST_LOCKED;
        lock_idx_d = win_idx;
      end else begin
        state_d  = ST_OPEN;
        rr_ptr_d = wrap_add(win_idx, 1);
      end
    end else if (out_ready) begin
      out_full_d = 1'b0;
    end
  end

  // State commits on the falling edge; reset is active-high despite the port name.
  always_ff @(negedge clk) begin
    if (rst_n) begin
      state_q    <= ST_OPEN;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      last_win_q <= '0;
      out_full_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      last_win_q <= last_win_d;
      out_full_q <= out_full_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_full_q;
  assign locked    = (state_q == ST_LOCKED);
  assign grant_idx = (state_q == ST_LOCKED) ? lock_idx_q : last_win_q;

endmodule

// File: tb/tb_flit_stream_arbiter.sv
// Bench for flit_stream_arbiter: directed scenarios followed by random traffic, checked
// against a message-level reference model and an output scoreboard.
module tb_flit_stream_arbiter;
  localparam int N     = 4;
  localparam int LG    = 2;
  localparam int W     = 16;
  localparam int DEPTH = 512;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0][W-1:0]  in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [W-1:0]         out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 locked;
  logic [LG-1:0]        grant_idx;

  always #5 clk = ~clk;

  flit_stream_arbiter #(.NUM_IN(N), .LOG_IN(LG), .FLIT_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .locked    (locked),
    .grant_idx (grant_idx)
  );

  // Per-port upstream flit sources (ring buffers) and the expected output stream.
  logic [W-1:0] src_mem [N][DEPTH];
  int           src_hd [N];
  int           src_tl [N];
  logic [W-1:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int seq = 0;

  // Reference model state, in terms of the arbitration rules.
  bit m_full, m_lock, checks_on;
  int m_lock_idx, m_ptr, m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_msg(input int p, input int len, input bit idle);
    logic [W-1:0] f;
    for (int j = 0; j < len; j++) begin
      f = '0;
      f[W-1]   = (j < len - 1);
      f[W-2]   = idle;
      f[13:12] = 2'(p);
      f[11:0]  = 12'(seq);
      seq++;
      src_mem[p][src_tl[p] % DEPTH] = f;
      src_tl[p]++;
    end
  endtask

  function automatic int pending(input int p);
    return src_tl[p] - src_hd[p];
  endfunction

  // One clock cycle: drive inputs after the rising edge, check and advance the model
  // before the falling (committing) edge.
  task automatic cycle(input logic [N-1:0] vmask, input logic ordy, input logic rst);
    logic [N-1:0] er;
    logic [W-1:0] f;
    int  w;
    bit  ok, xfer;
    @(posedge clk);
    #1;
    rst_n     = rst;
    out_ready = ordy;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = vmask[i] && (pending(i) > 0);
      in_data[i]  = src_mem[i][src_hd[i] % DEPTH];
    end
    #1;
    w  = 0;
    ok = 0;
    if (m_lock) begin
      w  = m_lock_idx;
      ok = in_valid[w];
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!ok && in_valid[c]) begin
          w  = c;
          ok = 1;
        end
      end
    end
    xfer = ok && (!m_full || ordy) && !rst;
    er = '0;
    if (xfer) er[w] = 1'b1;
    if (checks_on) begin
      check("in_ready", 32'(in_ready), 32'(er));
      check("out_valid", 32'(out_valid), 32'(m_full));
      check("locked", 32'(locked), 32'(m_lock));
      check("grant_idx", 32'(grant_idx), m_lock ? m_lock_idx : m_last);
    end
    if (rst) begin
      m_full = 0; m_lock = 0; m_lock_idx = 0; m_ptr = 0; m_last = 0;
      exp_q.delete();
      checks_on = 1;
    end else if (xfer) begin
      f = in_data[w];
      exp_q.push_back(f);
      src_hd[w]++;
      m_last = w;
      m_full = 1;
      if (f[W-1]) begin
        m_lock = 1;
        m_lock_idx = w;
      end else begin
        m_lock = 0;
        m_ptr = (w + 1) % N;
      end
    end else if (ordy) begin
      m_full = 0;
    end
  endtask

  // Output monitor: the held flit must match the scoreboard head; it leaves on out_ready.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (checks_on && !rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL out_data: got %0h with nothing expected at %0t", out_data, $time);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b1;
    out_ready = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    for (int i = 0; i < N; i++) begin
      src_hd[i] = 0;
      src_tl[i] = 0;
    end

    // Reset held with every port offering a flit.
    for (int i = 0; i < N; i++) push_msg(i, 1, 0);
    for (int i = 0; i < N; i++) push_msg(i, 1, 0);
    repeat (3) cycle(4'hF, 1'b1, 1'b1);

    // Round robin, single-flit messages, no backpressure.
    repeat (10) cycle(4'hF, 1'b1, 1'b0);

    // Message lock: steer pointer to port 2 via a lone port-1 flit, then 2 holds 3 flits.
    push_msg(1, 1, 0);
    cycle(4'b0010, 1'b1, 1'b0);
    push_msg(2, 3, 0);
    push_msg(0, 1, 0);
    push_msg(3, 1, 0);
    repeat (7) cycle(4'b1101, 1'b1, 1'b0);

    // Lock stall: port 1 goes quiet mid-message while port 0 waits.
    push_msg(1, 3, 0);
    push_msg(0, 2, 0);
    cycle(4'b0010, 1'b1, 1'b0);
    repeat (4) cycle(4'b0001, 1'b1, 1'b0);
    repeat (6) cycle(4'b0011, 1'b1, 1'b0);

    // Backpressure with a full slot, then drain and refill together.
    for (int i = 0; i < N; i++) push_msg(i, 2, 0);
    cycle(4'hF, 1'b1, 1'b0);
    repeat (5) cycle(4'hF, 1'b0, 1'b0);
    repeat (8) cycle(4'hF, 1'b1, 1'b0);

    // Reset after the first flit of a port-2 message.
    push_msg(2, 3, 0);
    push_msg(0, 1, 0);
    cycle(4'b0100, 1'b1, 1'b0);
    cycle(4'hF, 1'b1, 1'b1);
    repeat (5) cycle(4'b0101, 1'b1, 1'b0);

    // Random traffic including idle tokens and occasional resets.
    for (int t = 0; t < 600; t++) begin
      logic [N-1:0] vm;
      for (int i = 0; i < N; i++) begin
        if (pending(i) < 4) begin
          if ($urandom_range(0, 7) == 0) push_msg(i, 1, 1);
          else push_msg(i, $urandom_range(1, 4), 0);
        end
        vm[i] = ($urandom_range(0, 3) != 0);
      end
      cycle(vm, ($urandom_range(0, 3) != 0), ($urandom_range(0, 149) == 0));
    end

    // Drain whatever is left in the slot.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle('0, 1'b1, 1'b0);
    cycle('0, 1'b1, 1'b0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
